// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage access / MEM-WB register slice.
package mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SEL_ALU   = 2'd0,
    SEL_RDATA = 2'd1,
    SEL_ERR   = 2'd2
  } wb_sel_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'h0;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_access_wb_if.sv
// Data-memory req/ack bus between the MEM stage and the memory.
interface mem_access_wb_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: write enable always updated (bubble forces 0),
// data and destination loaded only when en is set.
module mem_wb_reg
  import mem_pkg::*;
#(
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        bubble,
  input  logic        wreg,
  input  wb_sel_t     sel,
  input  logic [31:0] alu_data,
  input  logic [31:0] rd_data,
  input  logic [31:0] reg_addr,
  output logic        WB_WREG,
  output logic [31:0] WB_DATA,
  output logic [31:0] WB_REG_ADDR
);

  logic [31:0] data_mux;

  always_comb begin
    data_mux = alu_data;
    case (sel)
      SEL_RDATA: data_mux = rd_data;
      SEL_ERR:   data_mux = ERR_DATA;
      default:   data_mux = alu_data;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WB_WREG     <= 1'b0;
      WB_DATA     <= '0;
      WB_REG_ADDR <= '0;
    end else begin
      WB_WREG <= bubble ? 1'b0 : wreg;
      if (en) begin
        WB_DATA     <= data_mux;
        WB_REG_ADDR <= reg_addr;
      end
    end
  end

endmodule

// File: rtl/mem_access_wb.sv
// MEM stage: runs data-memory accesses over req/ack, stalls upstream while
// an access is outstanding, and feeds the MEM/WB register.
module mem_access_wb
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MWREG,
  input  logic            MM2REG,
  input  logic            MWMEM,
  input  logic [31:0]     DATA_MEM_A,
  input  logic [31:0]     DATA_MEM_WD,
  input  logic [31:0]     MEM_REG_ADDR,
  mem_access_wb_if.master mem,
  output logic            mem_stall,
  output logic            WB_WREG,
  output logic [31:0]     WB_DATA,
  output logic [31:0]     WB_REG_ADDR,
  output logic            bus_err
);

  localparam int unsigned CW = clog2(TIMEOUT);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          memop, misalign, timeout_hit;
  logic          issue, finish, err_set;
  logic          wb_en, wb_bubble;
  wb_sel_t       wb_sel;

  assign memop       = MM2REG | MWMEM;
  assign misalign    = memop & (DATA_MEM_A[1:0] != 2'b00);
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nx  = state;
    mem_stall = 1'b0;
    issue     = 1'b0;
    finish    = 1'b0;
    err_set   = 1'b0;
    wb_en     = 1'b0;
    wb_bubble = 1'b1;
    wb_sel    = SEL_ALU;
    case (state)
      IDLE: begin
        if (!memop) begin
          wb_en     = 1'b1;
          wb_bubble = 1'b0;
        end else if (misalign) begin
          err_set = 1'b1;
        end else begin
          mem_stall = 1'b1;
          issue     = 1'b1;
          state_nx  = BUSY;
        end
      end
      BUSY: begin
        mem_stall = !(mem.mem_ack | timeout_hit);
        // Ack wins over a coincident timeout; stores never write back.
        if (mem.mem_ack | timeout_hit) begin
          finish    = 1'b1;
          state_nx  = IDLE;
          wb_en     = 1'b1;
          wb_bubble = MWMEM;
          wb_sel    = mem.mem_ack ? SEL_RDATA : SEL_ERR;
          err_set   = !mem.mem_ack;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      bus_err       <= 1'b0;
    end else begin
      state <= state_nx;
      if (issue) begin
        cnt           <= '0;
        mem.mem_req   <= 1'b1;
        mem.mem_we    <= MWMEM;
        mem.mem_addr  <= DATA_MEM_A;
        mem.mem_wdata <= DATA_MEM_WD;
      end else if (state == BUSY) begin
        cnt <= cnt + CW'(1);
        if (finish) mem.mem_req <= 1'b0;
      end
      if (err_set) bus_err <= 1'b1;
    end
  end

  mem_wb_reg #(.ERR_DATA(ERR_DATA)) u_wb (
    .clk        (clk),
    .rst        (rst),
    .en         (wb_en),
    .bubble     (wb_bubble),
    .wreg       (MWREG),
    .sel        (wb_sel),
    .alu_data   (DATA_MEM_A),
    .rd_data    (mem.mem_rdata),
    .reg_addr   (MEM_REG_ADDR),
    .WB_WREG    (WB_WREG),
    .WB_DATA    (WB_DATA),
    .WB_REG_ADDR(WB_REG_ADDR)
  );

endmodule

// File: tb/tb_mem_access_wb.sv
// Scoreboard bench for mem_access_wb: expected bus requests and register
// write-backs are queued by the stimulus and popped by a negedge monitor.
module tb_mem_access_wb;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
  } wb_t;

  logic        clk, rst;
  logic        MWREG, MM2REG, MWMEM;
  logic [31:0] DATA_MEM_A, DATA_MEM_WD, MEM_REG_ADDR;
  logic        mem_stall, WB_WREG, bus_err;
  logic [31:0] WB_DATA, WB_REG_ADDR;

  mem_access_wb_if bus ();

  mem_access_wb #(.TIMEOUT(16), .ERR_DATA(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .MWREG       (MWREG),
    .MM2REG      (MM2REG),
    .MWMEM       (MWMEM),
    .DATA_MEM_A  (DATA_MEM_A),
    .DATA_MEM_WD (DATA_MEM_WD),
    .MEM_REG_ADDR(MEM_REG_ADDR),
    .mem         (bus),
    .mem_stall   (mem_stall),
    .WB_WREG     (WB_WREG),
    .WB_DATA     (WB_DATA),
    .WB_REG_ADDR (WB_REG_ADDR),
    .bus_err     (bus_err)
  );

  int   tests = 0;
  int   fails = 0;
  req_t exp_req[$];
  wb_t  exp_wb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a rising mem_req must match the next queued request; every
  // register-file write must match the next queued write-back.
  initial begin
    logic req_q;
    req_t r;
    wb_t  w;
    req_q = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.mem_req && !req_q) begin
          if (exp_req.size() == 0) begin
            tests++; fails++;
            $display("FAIL req_unexpected: addr %h", bus.mem_addr);
          end else begin
            r = exp_req.pop_front();
            check("req_we", {31'b0, bus.mem_we}, {31'b0, r.we});
            check("req_addr", bus.mem_addr, r.addr);
            check("req_wdata", bus.mem_wdata, r.wdata);
          end
        end
        if (WB_WREG) begin
          if (exp_wb.size() == 0) begin
            tests++; fails++;
            $display("FAIL wb_unexpected: data %h addr %h", WB_DATA, WB_REG_ADDR);
          end else begin
            w = exp_wb.pop_front();
            check("wb_data", WB_DATA, w.data);
            check("wb_addr", WB_REG_ADDR, w.addr);
          end
        end
      end
      req_q = bus.mem_req;
    end
  end

  task automatic nop();
    MWREG = 0; MM2REG = 0; MWMEM = 0;
    DATA_MEM_A = '0; DATA_MEM_WD = '0; MEM_REG_ADDR = '0;
  endtask

  // Called just after a posedge in IDLE. n_ack: BUSY cycle (1-based) that
  // acks, 0 for never. Returns just after the edge that ends the access.
  task automatic mem_op(input logic ld, st, wreg, input logic [31:0] a, wd, ra, rd,
                        input int n_ack, output int req_n, output int stall_n,
                        output bit bub_bad);
    bit done;
    MWREG = wreg; MM2REG = ld; MWMEM = st;
    DATA_MEM_A = a; DATA_MEM_WD = wd; MEM_REG_ADDR = ra;
    req_n = 0; stall_n = 0; bub_bad = 0;
    @(negedge clk);
    if (mem_stall) stall_n++;
    if (bus.mem_req) req_n++;
    for (int b = 1; b <= 40; b++) begin
      @(posedge clk); #1;
      bus.mem_ack   = (b == n_ack);
      bus.mem_rdata = (b == n_ack) ? rd : 32'hDEADBEEF;
      @(negedge clk);
      if (bus.mem_req) req_n++;
      if (WB_WREG) bub_bad = 1;
      done = !mem_stall;
      if (mem_stall) stall_n++;
      if (done) break;
    end
    @(posedge clk); #1;
    bus.mem_ack = 0;
    nop();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    int req_n, stall_n;
    bit bub;
    rst = 1;
    bus.mem_ack = 0;
    bus.mem_rdata = '0;
    nop();
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'b0, bus.mem_req}, 32'd0);
    check("rst_wreg", {31'b0, WB_WREG}, 32'd0);
    check("rst_err", {31'b0, bus_err}, 32'd0);
    check("rst_wb_data", WB_DATA, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    rst = 0;

    // ALU op
    MWREG = 1; DATA_MEM_A = 32'h1234; MEM_REG_ADDR = 32'd5;
    exp_wb.push_back('{data: 32'h1234, addr: 32'd5});
    @(negedge clk);
    check("alu_stall", {31'b0, mem_stall}, 32'd0);
    check("alu_req", {31'b0, bus.mem_req}, 32'd0);
    @(posedge clk); #1;
    nop();
    @(negedge clk);
    check("alu_wreg", {31'b0, WB_WREG}, 32'd1);
    @(posedge clk); #1;

    // Load, ack in the 3rd BUSY cycle
    exp_req.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
    exp_wb.push_back('{data: 32'hCAFEF00D, addr: 32'd8});
    mem_op(1, 0, 1, 32'h100, 32'h0, 32'd8, 32'hCAFEF00D, 3, req_n, stall_n, bub);
    check("ld_req_cycles", req_n, 3);
    check("ld_stall_cycles", stall_n, 3);
    check("ld_bubble", {31'b0, bub}, 32'd0);
    @(negedge clk);
    check("ld_wreg", {31'b0, WB_WREG}, 32'd1);
    check("ld_stall_after", {31'b0, mem_stall}, 32'd0);
    @(posedge clk); #1;

    // Store, ack in the 1st BUSY cycle
    exp_req.push_back('{we: 1'b1, addr: 32'h40, wdata: 32'hA5A5A5A5});
    mem_op(0, 1, 0, 32'h40, 32'hA5A5A5A5, 32'd3, 32'h0, 1, req_n, stall_n, bub);
    check("st_req_cycles", req_n, 1);
    check("st_stall_cycles", stall_n, 1);
    @(negedge clk);
    check("st_wreg", {31'b0, WB_WREG}, 32'd0);
    check("st_err", {31'b0, bus_err}, 32'd0);
    check("st_req_after", {31'b0, bus.mem_req}, 32'd0);
    @(posedge clk); #1;

    // Load+store together with MWREG: a store, no write-back
    exp_req.push_back('{we: 1'b1, addr: 32'h80, wdata: 32'h5555AAAA});
    mem_op(1, 1, 1, 32'h80, 32'h5555AAAA, 32'd9, 32'h11111111, 2, req_n, stall_n, bub);
    check("ldst_req_cycles", req_n, 2);
    @(negedge clk);
    check("ldst_wreg", {31'b0, WB_WREG}, 32'd0);
    @(posedge clk); #1;

    // Ack exactly on the timeout cycle: normal completion, no error
    exp_req.push_back('{we: 1'b0, addr: 32'h104, wdata: 32'h0});
    exp_wb.push_back('{data: 32'h0BADF00D, addr: 32'd12});
    mem_op(1, 0, 1, 32'h104, 32'h0, 32'd12, 32'h0BADF00D, 16, req_n, stall_n, bub);
    check("ack16_req_cycles", req_n, 16);
    @(negedge clk);
    check("ack16_err", {31'b0, bus_err}, 32'd0);
    @(posedge clk); #1;

    // Misaligned load: squashed, error flagged, no request
    MWREG = 1; MM2REG = 1; DATA_MEM_A = 32'h42; MEM_REG_ADDR = 32'd7;
    @(negedge clk);
    check("mis_stall", {31'b0, mem_stall}, 32'd0);
    check("mis_req", {31'b0, bus.mem_req}, 32'd0);
    @(posedge clk); #1;
    nop();
    @(negedge clk);
    check("mis_err", {31'b0, bus_err}, 32'd1);
    check("mis_wreg", {31'b0, WB_WREG}, 32'd0);
    check("mis_req_after", {31'b0, bus.mem_req}, 32'd0);

    do_reset();
    // Put nonzero data in WB_DATA so the aborted load is distinguishable
    MWREG = 1; DATA_MEM_A = 32'h77; MEM_REG_ADDR = 32'd2;
    exp_wb.push_back('{data: 32'h77, addr: 32'd2});
    @(posedge clk); #1;
    nop();
    @(posedge clk); #1;

    // Load that never gets an ack
    exp_req.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0});
    exp_wb.push_back('{data: 32'h0, addr: 32'd4});
    mem_op(1, 0, 1, 32'h200, 32'h0, 32'd4, 32'h0, 0, req_n, stall_n, bub);
    check("to_req_cycles", req_n, 16);
    check("to_bubble", {31'b0, bub}, 32'd0);
    @(negedge clk);
    check("to_err", {31'b0, bus_err}, 32'd1);
    check("to_stall", {31'b0, mem_stall}, 32'd0);
    check("to_req_after", {31'b0, bus.mem_req}, 32'd0);
    @(posedge clk); #1;

    // Reset in the 2nd BUSY cycle, then a stray ack
    exp_req.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0});
    MWREG = 1; MM2REG = 1; DATA_MEM_A = 32'h300; MEM_REG_ADDR = 32'd6;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    nop();
    #1;
    check("mr_req", {31'b0, bus.mem_req}, 32'd0);
    check("mr_mem_addr", bus.mem_addr, 32'h0);
    check("mr_err", {31'b0, bus_err}, 32'd0);
    check("mr_stall", {31'b0, mem_stall}, 32'd0);
    check("mr_wb_addr", WB_REG_ADDR, 32'h0);
    @(posedge clk); #1;
    rst = 0;
    bus.mem_ack = 1; bus.mem_rdata = 32'h12345678;
    @(posedge clk); #1;
    bus.mem_ack = 0;
    @(negedge clk);
    check("mr_late_wreg", {31'b0, WB_WREG}, 32'd0);
    check("mr_late_req", {31'b0, bus.mem_req}, 32'd0);

    repeat (3) @(posedge clk);
    check("left_req", exp_req.size(), 0);
    check("left_wb", exp_wb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
